// File: rtl/riscv_seq_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROR unit, STEP bits per cycle.
// Start/busy/done handshake; result held until the next completion.
module riscv_seq_shifter #(
   parameter int WIDTH   = 32,
   parameter int STEP    = 1,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [SHAMT_W:0] STEP_L  = (SHAMT_W+1)'(STEP);
   localparam logic [SHAMT_W:0] WIDTH_L = (SHAMT_W+1)'(WIDTH);

   state_t             state;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   acc_nxt;
   logic [1:0]         op_q;
   logic [SHAMT_W-1:0] rem;
   logic [SHAMT_W-1:0] rem_nxt;
   logic [SHAMT_W:0]   n;
   logic [SHAMT_W:0]   lsh;

   // One step: shift by min(STEP, rem); n never exceeds rem so rem cannot wrap
   always_comb begin
      n       = ({1'b0, rem} < STEP_L) ? {1'b0, rem} : STEP_L;
      lsh     = WIDTH_L - n;
      rem_nxt = rem - n[SHAMT_W-1:0];
      acc_nxt = acc;
      unique case (op_q)
         2'b00: acc_nxt = acc << n;
         2'b01: acc_nxt = acc >> n;
         2'b10: acc_nxt = $signed(acc) >>> n;
         2'b11: acc_nxt = (acc >> n) | (acc << lsh);
         default: acc_nxt = acc;
      endcase
   end

   // Control FSM with registered busy/done/result
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         acc    <= '0;
         op_q   <= '0;
         rem    <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            SHIFT: begin
               acc <= acc_nxt;
               rem <= rem_nxt;
               if (rem_nxt == '0) begin
                  state  <= DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  result <= acc_nxt;
               end
            end
            IDLE, DONE: begin
               if (start) begin
                  acc  <= a;
                  op_q <= op;
                  rem  <= shamt;
                  if (shamt == '0) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     result <= a;
                  end else begin
                     state <= SHIFT;
                     busy  <= 1'b1;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
